// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types for the execute-stage issue/hazard controller: pipeline slot
// record, forward-select encoding and the forward priority helper.
package ex_issue_ctrl_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } SlotInfo;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } FwdSel;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Selects are aligned with the consumer's EX cycle, so the producer now in
    // EX is read from alu_out and the one now in MEM from alu_out_ff. Load data
    // is muxed onto alu_out one stage late, so a load now in MEM also maps to 1.
    function automatic FwdSel fwd_pick(input logic uses, input logic ex_hit,
                                       input logic mem_hit, input logic mem_is_load);
        if (!uses)   return FWD_RF;
        if (ex_hit)  return FWD_MEM;
        if (mem_hit) return mem_is_load ? FWD_MEM : FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_hazard_match.sv
// One slot against one source register: does the slot write it, and is that
// write a load result.
module hazard_match
    import ex_issue_ctrl_pkg::*;
(
    input  SlotInfo    slot,
    input  logic [4:0] src,
    output logic       hit,
    output logic       load_hit
);

    assign hit      = slot.valid & slot.reg_write & (slot.rd == src) & (src != REG_ZERO);
    assign load_hit = hit & slot.mem_read;

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue/hazard controller for EX: slot scoreboard for EX/MEM/WB, load-use and
// long-latency stalls, and registered operand-forward selects.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_multi,
    output logic       issue,
    output logic       stall,
    output logic       ex_valid,
    output logic       ex_hold,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel
);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MULTI_LAT - 1);

    SlotInfo              ex_s, mem_s, wb_s, id_s;
    SlotInfo [2:0]        slots;
    logic    [CNT_W-1:0]  cnt;
    logic    [2:0]        hit_rs1, hit_rs2, ld_rs1, ld_rs2;
    logic                 load_use;

    assign id_s  = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
    assign slots = {wb_s, mem_s, ex_s};

    // index 0 = EX, 1 = MEM, 2 = WB
    for (genvar s = 0; s < 3; s++) begin : g_slot
        hazard_match u_rs1 (.slot(slots[s]), .src(id_rs1), .hit(hit_rs1[s]), .load_hit(ld_rs1[s]));
        hazard_match u_rs2 (.slot(slots[s]), .src(id_rs2), .hit(hit_rs2[s]), .load_hit(ld_rs2[s]));
    end

    // WB results reach the consumer through the write-through regfile.
    logic unused_matches;
    assign unused_matches = ^{hit_rs1[2], hit_rs2[2], ld_rs1[2:1], ld_rs2[2:1]};

    assign load_use = id_valid & ((id_uses_rs1 & ld_rs1[0]) | (id_uses_rs2 & ld_rs2[0]));
    assign ex_hold  = (cnt != '0);
    assign stall    = ~rst & id_valid & (ex_hold | load_use);
    assign issue    = ~rst & id_valid & ~stall & ~flush;
    assign ex_valid = ex_s.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s        <= '0;
            mem_s       <= '0;
            wb_s        <= '0;
            cnt         <= '0;
            fwd_rs1_sel <= FWD_RF;
            fwd_rs2_sel <= FWD_RF;
        end else begin
            wb_s <= mem_s;
            // a flushed EX instruction is killed, never handed on to MEM
            mem_s <= (flush || ex_hold) ? '0 : ex_s;

            if (flush)         ex_s <= '0;
            else if (!ex_hold) ex_s <= issue ? id_s : '0;

            if (flush)                  cnt <= '0;
            else if (ex_hold)           cnt <= cnt - 1'b1;
            else if (issue && id_multi) cnt <= HOLD_INIT;

            fwd_rs1_sel <= issue ? fwd_pick(id_uses_rs1, hit_rs1[0], hit_rs1[1], mem_s.mem_read) : FWD_RF;
            fwd_rs2_sel <= issue ? fwd_pick(id_uses_rs2, hit_rs2[0], hit_rs2[1], mem_s.mem_read) : FWD_RF;
        end
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against an occupancy model.
module tb_ex_issue_ctrl;

    localparam int ML = 4;

    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic       id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_multi = 1'b0;
    logic       issue, stall, ex_valid, ex_hold;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    ex_issue_ctrl #(.MULTI_LAT(ML), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multi(id_multi),
        .issue(issue), .stall(stall), .ex_valid(ex_valid), .ex_hold(ex_hold),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_en = 0;

    // model: pipe[0]=EX, [1]=MEM, [2]=WB; rem = EX cycles left for the occupant
    typedef struct { bit v; int rd; bit rw; bit ld; } ins_t;
    ins_t pipe[3];
    int   rem = 0, m_f1 = 0, m_f2 = 0;

    function automatic bit writes(ins_t s, int r);
        return s.v && s.rw && r != 0 && s.rd == r;
    endfunction

    function automatic int pick(bit u, int r);
        if (!u) return 0;
        if (writes(pipe[0], r)) return 1;
        if (writes(pipe[1], r)) return pipe[1].ld ? 1 : 2;
        return 0;
    endfunction

    function automatic bit exp_lu();
        return id_valid && pipe[0].ld &&
               ((id_uses_rs1 && writes(pipe[0], id_rs1)) || (id_uses_rs2 && writes(pipe[0], id_rs2)));
    endfunction

    function automatic bit exp_stall();
        return !rst && id_valid && (rem > 1 || exp_lu());
    endfunction

    function automatic bit exp_issue();
        return !rst && id_valid && !exp_stall() && !flush;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ins_t bub, nw;
        bit   is;
        int   s1, s2;
        bub = '{0, 0, 0, 0};
        nw  = '{1, int'(id_rd), id_reg_write, id_mem_read};
        is  = exp_issue();
        s1  = pick(id_uses_rs1, int'(id_rs1));
        s2  = pick(id_uses_rs2, int'(id_rs2));
        if (rst) begin
            pipe[0] = bub; pipe[1] = bub; pipe[2] = bub;
            rem = 0; m_f1 = 0; m_f2 = 0;
        end else if (flush) begin
            pipe[2] = pipe[1]; pipe[1] = bub; pipe[0] = bub;
            rem = 0; m_f1 = 0; m_f2 = 0;
        end else if (rem > 1) begin
            pipe[2] = pipe[1]; pipe[1] = bub;
            rem--; m_f1 = 0; m_f2 = 0;
        end else begin
            pipe[2] = pipe[1]; pipe[1] = pipe[0];
            pipe[0] = is ? nw : bub;
            rem  = is ? (id_multi ? ML : 1) : 0;
            m_f1 = is ? s1 : 0;
            m_f2 = is ? s2 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_issue", issue, exp_issue());
            chk("m_stall", stall, exp_stall());
            chk("m_hold", ex_hold, rem > 1);
            chk("m_exv", ex_valid, pipe[0].v);
            chk("m_fwd1", fwd_rs1_sel, m_f1);
            chk("m_fwd2", fwd_rs2_sel, m_f2);
        end
    end

    task automatic put(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit ml);
        id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = 5'(rd); id_reg_write = rw; id_mem_read = ld; id_multi = ml;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        put(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick(); chk_en = 1;
        neg(); chk("rst_issue", issue, 0); chk("rst_stall", stall, 0);
        tick();
        neg(); chk("rst_exv", ex_valid, 0); chk("rst_fwd", fwd_rs1_sel, 0); chk("rst_hold", ex_hold, 0);
        tick(); rst = 0;

        // back-to-back dependency: EX forward on both sources
        put(1, 0, 0, 0, 0, 1, 1, 0, 0); neg(); chk("a_issue1", issue, 1); tick();
        put(1, 1, 1, 1, 1, 2, 1, 0, 0); neg(); chk("a_issue2", issue, 1); chk("a_stall", stall, 0); tick();
        idle(); neg(); chk("a_fwd1", fwd_rs1_sel, 1); chk("a_fwd2", fwd_rs2_sel, 1); tick();

        // distance two: MEM forward, then x0 never forwards
        put(1, 0, 0, 0, 0, 3, 1, 0, 0); tick(); idle(); tick();
        put(1, 3, 5, 1, 1, 4, 1, 0, 0); tick();
        idle(); neg(); chk("b_fwd1", fwd_rs1_sel, 2); chk("b_fwd2", fwd_rs2_sel, 0); tick();
        put(1, 0, 0, 0, 0, 0, 1, 0, 0); tick(); idle(); tick();
        put(1, 0, 5, 1, 1, 4, 1, 0, 0); tick();
        idle(); neg(); chk("b0_fwd1", fwd_rs1_sel, 0); chk("b0_fwd2", fwd_rs2_sel, 0); tick();

        // load-use: one stall cycle, then forward from alu_out
        put(1, 0, 0, 0, 0, 6, 1, 1, 0); tick();
        put(1, 6, 0, 1, 1, 7, 1, 0, 0); neg(); chk("c_stall", stall, 1); chk("c_noissue", issue, 0); tick();
        neg(); chk("c_stall_off", stall, 0); chk("c_issue", issue, 1); chk("c_bubble", ex_valid, 0); tick();
        idle(); neg(); chk("c_fwd1", fwd_rs1_sel, 1); chk("c_fwd2", fwd_rs2_sel, 0); tick();

        // long-latency hold
        put(1, 0, 0, 0, 0, 8, 1, 0, 1); neg(); chk("d_issue", issue, 1); tick();
        put(1, 8, 8, 1, 1, 9, 1, 0, 0);
        for (int k = 0; k < ML - 1; k++) begin
            neg(); chk("d_hold", ex_hold, 1); chk("d_stall", stall, 1); chk("d_fwd0", fwd_rs1_sel, 0); tick();
        end
        neg(); chk("d_hold_end", ex_hold, 0); chk("d_issue2", issue, 1); tick();
        idle(); neg(); chk("d_fwd1", fwd_rs1_sel, 1); chk("d_fwd2", fwd_rs2_sel, 1); tick();

        // flush on the second held cycle
        put(1, 0, 0, 0, 0, 8, 1, 0, 1); tick();
        put(1, 8, 8, 1, 1, 9, 1, 0, 0); tick();
        flush = 1; neg(); chk("e_noissue", issue, 0); tick();
        flush = 0; idle(); neg(); chk("e_exv", ex_valid, 0); chk("e_hold", ex_hold, 0); tick();

        // reset mid-hold
        put(1, 0, 0, 0, 0, 10, 1, 0, 1); tick(); idle(); tick();
        rst = 1; tick(); rst = 0;
        put(1, 10, 10, 1, 1, 11, 1, 0, 0);
        neg(); chk("f_exv", ex_valid, 0); chk("f_hold", ex_hold, 0); chk("f_fwd", fwd_rs1_sel, 0);
        chk("f_issue", issue, 1); tick();
        idle(); neg(); chk("f_fwd_after", fwd_rs1_sel, 0); tick();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 19) == 0);
            put($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            tick();
        end
        rst = 0; flush = 0; idle(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
